// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the CPU data bus.
// Registers: CTRL {IM, MODE[1:0], EN} at +0x0, PRESET at +0x4, COUNT (read-only) at +0x8.
// Mode 0 is one-shot with a sticky, level-held interrupt; any other mode reloads periodically
// and pulses irq for one cycle per period.
//
// Bus handshake: there is no valid/ready pair. A bus cycle is a write exactly when the
// address hits this block and all four byte enables are set, and the write is accepted at
// the next rising clock edge. Reads are purely combinational and have no side effects.
module timer_dev #(
  parameter logic [31:0] BASE     = 32'h0000_7F00,
  parameter logic [3:0]  RST_CTRL = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        sticky_q, sticky_d;

  logic [31:0] offset;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en_eff;

  // The subtraction wraps for addresses below BASE, so one unsigned compare covers both ends.
  assign offset    = addr - BASE;
  assign hit       = (offset < 32'd12);
  assign wr        = hit & (byteen == 4'b1111);
  assign wr_ctrl   = wr & (offset[3:2] == 2'd0);
  assign wr_preset = wr & (offset[3:2] == 2'd1);

  // An enabling CTRL write starts the timer on the same edge it lands, so IDLE looks at
  // the incoming EN rather than the stored one.
  assign en_eff    = wr_ctrl ? wdata[0] : ctrl_q[0];

  assign irq         = ctrl_q[3] & ((state_q == S_INT) | sticky_q);
  assign dbg_state_o = state_q;

  // Combinational read mux, zero outside the decoded window.
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (offset[3:2])
        2'd0:    rdata = {28'h0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'h0;
      endcase
    end
  end

  // Next-state logic: FSM update first, then bus writes override it for the same edge.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    case (state_q)
      S_IDLE: begin
        if (en_eff) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'h0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        // One-shot: drop EN and latch the interrupt; periodic: fall back and reload.
        if (ctrl_q[2:1] == 2'b00) begin
          ctrl_d[0] = 1'b0;
          sticky_d  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_d   = wdata[3:0];
      sticky_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = wdata;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= RST_CTRL;
      preset_q <= 32'h0;
      count_q  <= 32'h0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev at BASE 0x7F00: a table of single-cycle bus vectors, then hand-written
// multi-cycle sequences for one-shot, periodic, stop/restart, write priority and reset.
// Each cycle observes {state, hit, irq, rdata} on the falling edge.
module tb_timer_dev;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_LOAD = 2'd1;
  localparam logic [1:0]  S_CNT  = 2'd2;
  localparam logic [1:0]  S_INT  = 2'd3;
  localparam logic [35:0] M_ALL   = 36'hF_FFFF_FFFF;
  localparam logic [35:0] M_NOHIT = 36'hD_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  dbg_state;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [35:0] exp;
    logic [35:0] mask;
  } vec_t;

  vec_t        tbl[$];
  logic [35:0] exp_q[$];
  logic [35:0] msk_q[$];
  int          n_vec;
  int          n_err;

  timer_dev #(
    .BASE     (32'h0000_7F00),
    .RST_CTRL (4'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .byteen      (byteen),
    .hit         (hit),
    .rdata       (rdata),
    .irq         (irq),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] mk(input logic [1:0] st, input logic h, input logic q,
                                     input logic [31:0] rd);
    return {st, h, q, rd};
  endfunction

  // Drive one bus cycle after the rising edge, push its expectation, compare on the falling edge.
  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [35:0] e, input logic [35:0] m,
                      input string nm);
    logic [35:0] got;
    logic [35:0] want;
    logic [35:0] msk;
    @(posedge clk);
    #1;
    reset  = rst;
    addr   = a;
    wdata  = d;
    byteen = be;
    exp_q.push_back(e);
    msk_q.push_back(m);
    @(negedge clk);
    got  = {dbg_state, hit, irq, rdata};
    want = exp_q.pop_front();
    msk  = msk_q.pop_front();
    n_vec++;
    if ((got & msk) !== (want & msk)) begin
      n_err++;
      $display("FAIL %s: got {st,hit,irq,rdata}=%h expected %h (mask %h)", nm, got, want, msk);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [35:0] e, input string nm);
    step(1'b1, a, 32'h0, 4'h0, e, M_ALL, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [35:0] e,
                    input string nm);
    step(1'b1, a, d, 4'hF, e, M_ALL, nm);
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [35:0] e, input logic [35:0] m);
    vec_t v;
    v.addr   = a;
    v.wdata  = d;
    v.byteen = be;
    v.exp    = e;
    v.mask   = m;
    tbl.push_back(v);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h0;
    byteen = 4'h0;
    repeat (3) @(posedge clk);

    // Decode, read-back and write-filter vectors; the timer stays idle throughout.
    add(A_CTRL,       32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_PRE,        32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CNT,        32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(32'h7F0B,     32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(32'h7F0C,     32'h0,         4'h0, mk(S_IDLE, 0, 0, 32'h0),         M_NOHIT);
    add(32'h7F10,     32'h0,         4'h0, mk(S_IDLE, 0, 0, 32'h0),         M_ALL);
    add(32'h7EFC,     32'h0,         4'h0, mk(S_IDLE, 0, 0, 32'h0),         M_ALL);
    add(A_PRE,        32'h1234_5678, 4'hF, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_PRE,        32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h1234_5678), M_ALL);
    add(A_PRE,        32'h0000_FFFF, 4'h3, mk(S_IDLE, 1, 0, 32'h1234_5678), M_ALL);
    add(A_PRE,        32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h1234_5678), M_ALL);
    add(32'h7F07,     32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h1234_5678), M_ALL);
    add(A_CNT,        32'h0000_DEAD, 4'hF, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CNT,        32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(32'h7F10,     32'h0000_0005, 4'hF, mk(S_IDLE, 0, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0000_0006, 4'hF, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h6),         M_ALL);
    add(A_CTRL,       32'h0000_00F0, 4'hF, mk(S_IDLE, 1, 0, 32'h6),         M_ALL);
    add(A_CTRL,       32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0000_0009, 4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0000_0009, 4'hE, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CTRL,       32'h0000_0009, 4'h1, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);
    add(A_CNT,        32'h0,         4'h0, mk(S_IDLE, 1, 0, 32'h0),         M_ALL);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].addr, tbl[i].wdata, tbl[i].byteen, tbl[i].exp, tbl[i].mask,
           $sformatf("tbl%0d", i));
    end

    // One-shot, PRESET=5, IM=1: count 5..1, INT, then irq held until CTRL is rewritten.
    wr(A_PRE, 32'd5, mk(S_IDLE, 1, 0, 32'h1234_5678), "os_pre");
    wr(A_CTRL, 32'h9, mk(S_IDLE, 1, 0, 32'h0), "os_ctrl");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'h0), "os_load");
    for (int k = 5; k >= 1; k--) rd(A_CNT, mk(S_CNT, 1, 0, 32'(k)), "os_cnt");
    rd(A_CNT, mk(S_INT, 1, 1, 32'h0), "os_int");
    repeat (3) rd(A_CTRL, mk(S_IDLE, 1, 1, 32'h8), "os_hold");
    wr(A_CTRL, 32'h0, mk(S_IDLE, 1, 1, 32'h8), "os_clr");
    rd(A_CTRL, mk(S_IDLE, 1, 0, 32'h0), "os_irq_off");

    // Periodic, PRESET=3: one-cycle irq pulse every 6 cycles, reload to 3 each period.
    wr(A_PRE, 32'd3, mk(S_IDLE, 1, 0, 32'd5), "per_pre");
    wr(A_CTRL, 32'hB, mk(S_IDLE, 1, 0, 32'h0), "per_ctrl");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'h0), "per_load0");
    for (int p = 0; p < 3; p++) begin
      rd(A_CNT, mk(S_CNT, 1, 0, 32'd3), "per_c3");
      rd(A_CNT, mk(S_CNT, 1, 0, 32'd2), "per_c2");
      rd(A_CNT, mk(S_CNT, 1, 0, 32'd1), "per_c1");
      rd(A_CNT, mk(S_INT, 1, 1, 32'd0), "per_int");
      rd(A_CNT, mk(S_IDLE, 1, 0, 32'd0), "per_idle");
      rd(A_CNT, mk(S_LOAD, 1, 0, 32'd0), "per_load");
    end
    wr(A_CTRL, 32'h0, mk(S_CNT, 1, 0, 32'hB), "per_stop");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd2), "per_stop_cnt");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'd2), "per_stop_idle");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'd2), "per_stop_held");

    // Stop mid-count: EN cleared while COUNT=100 freezes at 99; PRESET write waits for LOAD.
    wr(A_PRE, 32'd102, mk(S_IDLE, 1, 0, 32'd3), "mid_pre");
    wr(A_CTRL, 32'h9, mk(S_IDLE, 1, 0, 32'h0), "mid_ctrl");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd2), "mid_load");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd102), "mid_c102");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd101), "mid_c101");
    wr(A_CTRL, 32'h8, mk(S_CNT, 1, 0, 32'h9), "mid_stop");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd99), "mid_c99");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'd99), "mid_frozen");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'd99), "mid_frozen2");
    wr(A_PRE, 32'd7, mk(S_IDLE, 1, 0, 32'd102), "mid_pre7");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'd99), "mid_pre_nochg");
    wr(A_CTRL, 32'h9, mk(S_IDLE, 1, 0, 32'h8), "mid_restart");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd99), "mid_reload");
    for (int k = 7; k >= 1; k--) rd(A_CNT, mk(S_CNT, 1, 0, 32'(k)), "mid_cnt");
    rd(A_CNT, mk(S_INT, 1, 1, 32'd0), "mid_int");
    rd(A_CTRL, mk(S_IDLE, 1, 1, 32'h8), "mid_sticky");

    // CTRL write landing in INT (mode 0): written EN survives and sticky stays clear.
    wr(A_PRE, 32'd1, mk(S_IDLE, 1, 1, 32'd7), "pri_pre");
    wr(A_CTRL, 32'h9, mk(S_IDLE, 1, 1, 32'h8), "pri_ctrl");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd0), "pri_load");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd1), "pri_c1");
    wr(A_CTRL, 32'h9, mk(S_INT, 1, 1, 32'h9), "pri_wr_int");
    rd(A_CTRL, mk(S_IDLE, 1, 0, 32'h9), "pri_en_kept");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd0), "pri_reload");
    // IM=0 expiry sets sticky silently; a later IM=1 write clears it, so irq stays low.
    wr(A_CTRL, 32'h0, mk(S_CNT, 1, 0, 32'h9), "im0_wr");
    rd(A_CTRL, mk(S_INT, 1, 0, 32'h0), "im0_int");
    rd(A_CTRL, mk(S_IDLE, 1, 0, 32'h0), "im0_idle");
    wr(A_CTRL, 32'h8, mk(S_IDLE, 1, 0, 32'h0), "im1_wr");
    rd(A_CTRL, mk(S_IDLE, 1, 0, 32'h8), "im1_no_irq");
    rd(A_CTRL, mk(S_IDLE, 1, 0, 32'h8), "im1_no_irq2");

    // PRESET=0 in periodic mode: LOAD, CNT, INT with no decrement; EN=0 write in IDLE holds.
    wr(A_PRE, 32'd0, mk(S_IDLE, 1, 0, 32'd1), "p0_pre");
    wr(A_CTRL, 32'hB, mk(S_IDLE, 1, 0, 32'h8), "p0_ctrl");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd0), "p0_load");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd0), "p0_cnt");
    rd(A_CNT, mk(S_INT, 1, 1, 32'd0), "p0_int");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'd0), "p0_idle");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd0), "p0_load2");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd0), "p0_cnt2");
    rd(A_CNT, mk(S_INT, 1, 1, 32'd0), "p0_int2");
    wr(A_CTRL, 32'h0, mk(S_IDLE, 1, 0, 32'hB), "p0_stop");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'd0), "p0_stay_idle");

    // Reset during CNT, coinciding with a CTRL write: reset wins.
    wr(A_PRE, 32'd4, mk(S_IDLE, 1, 0, 32'd0), "rst_pre");
    wr(A_CTRL, 32'hB, mk(S_IDLE, 1, 0, 32'h0), "rst_ctrl");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd0), "rst_load");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd4), "rst_c4");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd3), "rst_c3");
    step(1'b0, A_CTRL, 32'hF, 4'hF, mk(S_CNT, 1, 0, 32'hB), M_ALL, "rst_assert");
    rd(A_CTRL, mk(S_IDLE, 1, 0, 32'h0), "rst_ctrl0");
    rd(A_PRE, mk(S_IDLE, 1, 0, 32'h0), "rst_pre0");
    rd(A_CNT, mk(S_IDLE, 1, 0, 32'h0), "rst_cnt0");

    // Reset while the one-shot interrupt is being held high.
    wr(A_PRE, 32'd1, mk(S_IDLE, 1, 0, 32'd0), "rsti_pre");
    wr(A_CTRL, 32'h9, mk(S_IDLE, 1, 0, 32'h0), "rsti_ctrl");
    rd(A_CNT, mk(S_LOAD, 1, 0, 32'd0), "rsti_load");
    rd(A_CNT, mk(S_CNT, 1, 0, 32'd1), "rsti_c1");
    rd(A_CNT, mk(S_INT, 1, 1, 32'd0), "rsti_int");
    step(1'b0, A_CNT, 32'h0, 4'h0, mk(S_IDLE, 1, 1, 32'd0), M_ALL, "rsti_assert");
    rd(A_CTRL, mk(S_IDLE, 1, 0, 32'h0), "rsti_irq_off");
    rd(A_PRE, mk(S_IDLE, 1, 0, 32'h0), "rsti_pre0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
